// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, start/ready levels
// and bus widths used by the divider and the HI/LO write path.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int unsigned RegDataW    = 32;
    localparam int unsigned DoubleRegW  = 64;
    localparam logic [RegDataW-1:0] ZeroWord = '0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// result_o = {remainder, quotient}, valid while ready_o is high.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2*DATA_W:0]   dividend, dividend_n;
    logic [DATA_W-1:0]   divisor, divisor_n;
    logic                sgn, sgn_n;
    logic                op1_neg, op1_neg_n;
    logic                op2_neg, op2_neg_n;
    logic [2*DATA_W-1:0] result_n;
    logic                ready_n;

    logic [DATA_W:0]     minus;
    logic [DATA_W-1:0]   mag1, mag2, quot, rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            sgn      <= 1'b0;
            op1_neg  <= 1'b0;
            op2_neg  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            sgn      <= sgn_n;
            op1_neg  <= op1_neg_n;
            op2_neg  <= op2_neg_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        sgn_n      = sgn;
        op1_neg_n  = op1_neg;
        op2_neg_n  = op2_neg;
        result_n   = result_o;
        ready_n    = ready_o;

        mag1  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        minus = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
        // Remainder takes the dividend's sign, quotient the XOR of both signs.
        quot  = (sgn && (op1_neg ^ op2_neg)) ? -dividend[DATA_W-1:0] : dividend[DATA_W-1:0];
        rem   = (sgn && op1_neg) ? -dividend[2*DATA_W:DATA_W+1] : dividend[2*DATA_W:DATA_W+1];

        unique case (state)
            DivFree: begin
                ready_n  = DivResultNotReady;
                result_n = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = DivByZero;
                    end else begin
                        state_n    = DivOn;
                        cnt_n      = '0;
                        sgn_n      = signed_div_i;
                        op1_neg_n  = opdata1_i[DATA_W-1];
                        op2_neg_n  = opdata2_i[DATA_W-1];
                        divisor_n  = mag2;
                        dividend_n = {{DATA_W{1'b0}}, mag1, 1'b0};
                    end
                end
            end
            DivByZero: begin
                dividend_n = '0;
                result_n   = '0;
                state_n    = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_n = DivFree;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    if (minus[DATA_W]) begin
                        dividend_n = {dividend[2*DATA_W-1:0], 1'b0};
                    end else begin
                        dividend_n = {minus[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                    end
                    cnt_n = cnt + 1'b1;
                end else begin
                    result_n = {rem, quot};
                    ready_n  = DivResultReady;
                    cnt_n    = '0;
                    state_n  = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end else begin
                    ready_n = DivResultReady;
                end
            end
            default: state_n = DivFree;
        endcase
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU.
- Sits upstream of the HI/LO register file.
- EX stalls while a division runs; MEM/WB then writes remainder to HI and quotient to LO through the HI/LO write port.
- Handles signed and unsigned operands, divide-by-zero, and cancellation when EX is flushed.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request level; held high by EX until ready_o is seen
- annul_i  input  1  cancel request (pipeline flush/exception)
- result_o  output  64  {remainder[63:32], quotient[31:0]}; HI = [63:32], LO = [31:0]
- ready_o  output  1  result_o valid

Behaviour:
- Reset (async, any state): state=FREE, cnt=0, result_o=0, ready_o=0. Registers clear immediately, independent of clk.
- State machine: FREE, BYZERO, ON, END; state is 2 bits.
- FREE:
  - start_i=1 and annul_i=0 and opdata2_i==0 -> BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i!=0 -> ON. Latch operands, taking magnitude (two's complement negate) when signed_div_i=1 and the operand is negative. Latch signed_div_i and both operand sign bits. Load dividend register (65 bits) = {32'b0, |op1|, 1'b0}; cnt=0.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: load dividend register = 0, go to END with result 0. No exception is raised; the MIPS result is UNPREDICTABLE and 0 is the defined choice.
- ON:
  - annul_i=1 -> FREE immediately; no result; ready_o stays 0.
  - cnt<32: minus = dividend[63:32] - |op2| (33-bit).
    - If minus is negative: dividend = dividend << 1.
    - Else: dividend = {minus[31:0], dividend[31:0], 1'b1}.
    - cnt increments in both cases.
  - cnt==32, sign correction:
    - Quotient = dividend[31:0], negated if signed and sign(op1)!=sign(op2).
    - Remainder = dividend[64:33], negated if signed and op1 negative.
    - Go to END.
- END: ready_o=1, result_o=corrected value. Hold both while start_i=1. When start_i=0 -> FREE, ready_o=0, result_o=0.
- annul_i is ignored in END; EX deasserts start_i.
- Latency: start sampled at edge 0 -> ready_o high after edge 33 (normal) or after edge 2 (divide-by-zero: FREE->BYZERO->END).
- Operand changes after edge 0 have no effect; only the latched values are used.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 (wraps), remainder 0; no trap.
- The divider never writes HI/LO itself; the consumer qualifies writes with ready_o.

Decomposition:
- Shared define.vh gets:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivStart/DivStop, DivResultReady/DivResultNotReady.
  - `DoubleRegBus [63:0].
- Reuse the existing `RegDataBus and `ZeroWord.
- Single module; no sub-module is natural. The magnitude/negate helpers are inline expressions.

Test Plan:
- Unsigned 100 / 7, start held -> ready_o rises after edge 33; result_o=0x00000002_0000000E. Drop start -> next edge ready_o=0, result_o=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (5 / 0) -> ready_o after edge 2, result_o=0; no ON cycles.
- 0x80000000 / 0xFFFFFFFF: signed -> 0x00000000_80000000; unsigned -> 0x80000000_00000000.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o never asserts. A new start for 9 / 3 then yields 0x00000000_00000003 after edge 33.
- rst asserted mid-ON, between clock edges -> outputs 0 and state FREE immediately. After release, a new division completes correctly.
